// File: rtl/backoff_retry_pkg.sv
// rtl/backoff_retry_pkg.sv - shared types and constants for the backoff retry controller
package backoff_retry_pkg;

    // Controller states; encoding fixed so waveforms read the same across builds
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RESP = 3'd2,
        BACKOFF   = 3'd3,
        DONE      = 3'd4
    } state_e;

    // Width of the backoff LFSR, mask and countdown registers
    localparam int unsigned LfsrWidth = 16;

endpackage

// File: rtl/exp_backoff.sv
// rtl/exp_backoff.sv - randomized exponential backoff countdown
module exp_backoff
    import backoff_retry_pkg::*;
#(
    parameter int unsigned Seed   = 'hffff,
    parameter int unsigned MaxExp = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic set_i,
    input  logic clr_i,
    output logic is_zero_o
);

    // Caps the window growth at MaxExp low bits
    localparam logic [LfsrWidth-1:0] CapMask = LfsrWidth'((32'd1 << MaxExp) - 32'd1);

    logic [LfsrWidth-1:0] lfsr_q;
    logic [LfsrWidth-1:0] mask_q;
    logic [LfsrWidth-1:0] cnt_q;
    logic                 feedback;

    // Fibonacci taps 16,14,13,11 on a right-shifting register
    assign feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // set_i loads the wait from the window masked random value and then widens the
    // window, so the first backoff after a clear is always zero cycles
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            lfsr_q <= LfsrWidth'(Seed);
            mask_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            mask_q <= '0;
            cnt_q  <= '0;
        end else if (set_i) begin
            cnt_q  <= mask_q & lfsr_q;
            mask_q <= ((mask_q << 1) | LfsrWidth'(1)) & CapMask;
            lfsr_q <= {feedback, lfsr_q[LfsrWidth-1:1]};
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - LfsrWidth'(1);
        end
    end

    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/backoff_retry_ctrl.sv
// rtl/backoff_retry_ctrl.sv - single-request retry controller with exponential backoff
module backoff_retry_ctrl
    import backoff_retry_pkg::*;
#(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned MaxRetries    = 7,
    parameter int unsigned TimeoutCycles = 0,
    parameter int unsigned Seed          = 'hffff,
    parameter int unsigned MaxExp        = 16,
    localparam int unsigned RW           = $clog2(MaxRetries + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [DataWidth-1:0] req_data_i,
    output logic                 att_valid_o,
    input  logic                 att_ready_i,
    output logic [DataWidth-1:0] att_data_o,
    input  logic                 resp_valid_i,
    input  logic                 resp_ok_i,
    output logic                 done_valid_o,
    input  logic                 done_ready_i,
    output logic                 done_ok_o,
    output logic [RW-1:0]        done_retries_o
);

    localparam int unsigned TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    state_e               state_q;
    state_e               state_d;
    logic [DataWidth-1:0] data_q;
    logic [RW-1:0]        retry_cnt_q;
    logic [TW-1:0]        tmo_cnt_q;
    logic                 done_ok_q;

    logic capture;
    logic backoff_set;
    logic backoff_clr;
    logic retry_inc;
    logic ok_load;
    logic ok_val;
    logic timeout_hit;
    logic last_attempt;
    logic is_zero;

    assign timeout_hit  = (TimeoutCycles != 0) && (tmo_cnt_q == TW'(TimeoutCycles - 1));
    assign last_attempt = (retry_cnt_q == RW'(MaxRetries));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and transition strobes; a timeout is judged exactly like a NACK
    // and a real response in the same cycle takes precedence over it
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        backoff_set = 1'b0;
        backoff_clr = 1'b0;
        retry_inc   = 1'b0;
        ok_load     = 1'b0;
        ok_val      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    capture = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (att_ready_i) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (resp_valid_i || timeout_hit) begin
                    if (resp_valid_i && resp_ok_i) begin
                        backoff_clr = 1'b1;
                        ok_load     = 1'b1;
                        ok_val      = 1'b1;
                        state_d     = DONE;
                    end else if (last_attempt) begin
                        backoff_clr = 1'b1;
                        ok_load     = 1'b1;
                        state_d     = DONE;
                    end else begin
                        backoff_set = 1'b1;
                        retry_inc   = 1'b1;
                        state_d     = BACKOFF;
                    end
                end
            end
            BACKOFF: begin
                if (is_zero) begin
                    state_d = ISSUE;
                end
            end
            DONE: begin
                if (done_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from state and registered data only
    always_comb begin
        req_ready_o    = (state_q == IDLE);
        att_valid_o    = (state_q == ISSUE);
        done_valid_o   = (state_q == DONE);
        att_data_o     = data_q;
        done_ok_o      = done_ok_q;
        done_retries_o = retry_cnt_q;
    end

    // Payload capture, retry count, response timeout and final verdict
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q      <= '0;
            retry_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            done_ok_q   <= 1'b0;
        end else begin
            if (capture) begin
                data_q      <= req_data_i;
                retry_cnt_q <= '0;
            end else if (retry_inc) begin
                retry_cnt_q <= retry_cnt_q + RW'(1);
            end
            if (state_q == ISSUE) begin
                tmo_cnt_q <= '0;
            end else if (state_q == WAIT_RESP) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
            end
            if (capture) begin
                done_ok_q <= 1'b0;
            end else if (ok_load) begin
                done_ok_q <= ok_val;
            end
        end
    end

    exp_backoff #(
        .Seed   (Seed),
        .MaxExp (MaxExp)
    ) u_backoff (
        .clk_i     (clk_i),
        .rst_ni    (1'b1),
        .clear_i   (rst_i),
        .set_i     (backoff_set),
        .clr_i     (backoff_clr),
        .is_zero_o (is_zero)
    );

    if (MaxRetries < 1) begin : g_bad_max_retries
        $error("backoff_retry_ctrl: MaxRetries must be at least 1");
    end

    a_att_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (att_valid_o && !att_ready_i) |=> $stable(att_data_o));

    a_set_clr_exclusive: assert property (@(posedge clk_i)
        !(backoff_set && backoff_clr));

endmodule

// File: tb/tb_backoff_retry_ctrl.sv
// tb/tb_backoff_retry_ctrl.sv - directed self-checking bench for backoff_retry_ctrl
module tb_backoff_retry_ctrl;

    localparam int DW = 32;
    localparam int MR = 3;
    localparam int TC = 8;
    localparam int RW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_data;
    logic          att_valid;
    logic          att_ready;
    logic [DW-1:0] att_data;
    logic          resp_valid;
    logic          resp_ok;
    logic          done_valid;
    logic          done_ready;
    logic          done_ok;
    logic [RW-1:0] done_retries;

    int vectors     = 0;
    int miscompares = 0;
    int att_hs      = 0;
    int clr_pulses  = 0;
    int hs0;
    int clr0;

    always #5 clk = ~clk;

    backoff_retry_ctrl #(
        .DataWidth     (DW),
        .MaxRetries    (MR),
        .TimeoutCycles (TC),
        .Seed          ('hffff),
        .MaxExp        (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .att_valid_o    (att_valid),
        .att_ready_i    (att_ready),
        .att_data_o     (att_data),
        .resp_valid_i   (resp_valid),
        .resp_ok_i      (resp_ok),
        .done_valid_o   (done_valid),
        .done_ready_i   (done_ready),
        .done_ok_o      (done_ok),
        .done_retries_o (done_retries)
    );

    // Attempt handshakes and backoff clear pulses seen at the clock edge
    always @(posedge clk) begin
        if (att_valid && att_ready) att_hs <= att_hs + 1;
        if (dut.backoff_clr) clr_pulses <= clr_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        vectors++;
        assert (obs === expd) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_data  = d;
        step();
        req_valid = 1'b0;
        req_data  = '0;
    endtask

    task automatic handshake();
        att_ready = 1'b1;
        step();
        att_ready = 1'b0;
    endtask

    task automatic respond(input logic ok);
        resp_valid = 1'b1;
        resp_ok    = ok;
        step();
        resp_valid = 1'b0;
        resp_ok    = 1'b0;
    endtask

    task automatic finish_done();
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
    endtask

    task automatic wait_att(input string tag);
        int n = 0;
        while (!att_valid && n < 64) begin
            step();
            n++;
        end
        check({tag, " att_valid reached"}, att_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req_valid = 0; req_data = 0; att_ready = 0;
        resp_valid = 0; resp_ok = 0; done_ready = 0;
        step();
        step();
        check("rst req_ready", req_ready, 1);
        check("rst att_valid", att_valid, 0);
        check("rst done_valid", done_valid, 0);
        check("rst done_ok", done_ok, 0);
        check("rst done_retries", done_retries, 0);
        check("rst att_data", att_data, 0);
        rst = 1'b0;
        step();

        // Single successful attempt
        hs0 = att_hs;
        issue_req(32'hDEADBEEF);
        check("A att_valid", att_valid, 1);
        check("A req_ready", req_ready, 0);
        check("A att_data", att_data, 32'hDEADBEEF);
        handshake();
        respond(1'b1);
        check("A done_valid", done_valid, 1);
        check("A done_ok", done_ok, 1);
        check("A done_retries", done_retries, 0);
        check("A attempts", att_hs - hs0, 1);
        finish_done();
        check("A back to idle", req_ready, 1);

        // NACK then ok: zero first backoff, reissue two cycles after the NACK
        issue_req(32'hA5A50001);
        handshake();
        respond(1'b0);
        check("B gap cycle1", att_valid, 0);
        step();
        check("B reissue cycle2", att_valid, 1);
        handshake();
        respond(1'b1);
        check("B done_ok", done_ok, 1);
        check("B done_retries", done_retries, 1);
        finish_done();

        // Always NACK: MaxRetries+1 attempts then failure
        hs0  = att_hs;
        clr0 = clr_pulses;
        issue_req(32'h0BADF00D);
        for (int i = 0; i < 4; i++) begin
            wait_att("C");
            handshake();
            respond(1'b0);
        end
        check("C done_valid", done_valid, 1);
        check("C done_ok", done_ok, 0);
        check("C done_retries", done_retries, 3);
        check("C attempts", att_hs - hs0, 4);
        check("C clr pulses", clr_pulses - clr0, 1);
        finish_done();

        // No response: timeout eight cycles into WAIT_RESP acts as a NACK
        issue_req(32'h00C0FFEE);
        handshake();
        for (int i = 0; i < 7; i++) step();
        check("D still waiting", att_valid, 0);
        check("D no early timeout", done_retries, 0);
        step();
        check("D backoff att_valid", att_valid, 0);
        check("D backoff retries", done_retries, 1);
        step();
        check("D reissue", att_valid, 1);
        handshake();
        respond(1'b1);
        check("D done_ok", done_ok, 1);
        check("D done_retries", done_retries, 1);
        finish_done();

        // Stalled downstream with stray responses while in ISSUE
        issue_req(32'h12345678);
        for (int i = 0; i < 5; i++) begin
            resp_valid = (i == 2);
            resp_ok    = 1'b1;
            check("E att_valid held", att_valid, 1);
            check("E att_data held", att_data, 32'h12345678);
            step();
        end
        resp_valid = 1'b1;
        resp_ok    = 1'b1;
        att_ready  = 1'b1;
        step();
        att_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_ok    = 1'b0;
        check("E same-cycle resp ignored", done_valid, 0);
        check("E att_data after hs", att_data, 32'h12345678);
        respond(1'b1);
        check("E done_ok", done_ok, 1);
        check("E done_retries", done_retries, 0);
        finish_done();

        // Reset while backing off
        issue_req(32'h11110000);
        handshake();
        respond(1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("F req_ready", req_ready, 1);
        check("F done_valid", done_valid, 0);
        check("F att_valid", att_valid, 0);
        check("F done_retries", done_retries, 0);
        issue_req(32'h11110001);
        handshake();
        respond(1'b1);
        check("F next done_ok", done_ok, 1);
        check("F next done_retries", done_retries, 0);
        finish_done();

        // Reset while holding a result
        issue_req(32'h22220000);
        handshake();
        respond(1'b0);
        step();
        check("G reissue", att_valid, 1);
        handshake();
        respond(1'b1);
        step();
        check("G held done_valid", done_valid, 1);
        check("G held retries", done_retries, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("G req_ready", req_ready, 1);
        check("G done_valid", done_valid, 0);
        check("G done_retries", done_retries, 0);
        check("G done_ok", done_ok, 0);
        issue_req(32'h22220001);
        handshake();
        respond(1'b0);
        check("G next gap", att_valid, 0);
        step();
        check("G next zero backoff", att_valid, 1);
        handshake();
        respond(1'b1);
        check("G next done_ok", done_ok, 1);
        check("G next done_retries", done_retries, 1);
        finish_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
